sm_prog_loader: RTL and testbench

SM_PROG_LOADER -- requirements
Module: sm_prog_loader

---
 rtl/sm_prog_loader.sv | 131 +++++++++++++
 tb/tb_sm_prog_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_prog_loader.sv
// Byte-stream program loader: parses sync/count/data/checksum frames and writes 32-bit
// instruction words into memory while holding the CPU in reset.
module sm_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StCheck,
    StDone
  } state_e;

  state_e                  state_q;
  logic [7:0]              count_q;
  logic [7:0]              word_idx_q;
  logic [1:0]              byte_idx_q;
  logic [7:0]              csum_q;
  logic [23:0]             word_buf_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [31:0]             mem_wdata_q;
  logic                    cpu_rst_q;
  logic                    done_q;
  logic                    err_q;
  logic                    accept;

  assign in_ready = (state_q != StDone);
  assign accept   = in_valid && in_ready;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      word_buf_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle; address/data registers hold their last value.
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && in_data == SyncByte) begin
            state_q   <= StCount;
            cpu_rst_q <= 1'b1;
            err_q     <= 1'b0;
          end
        end
        StCount: begin
          if (accept) begin
            if (in_data == 8'd0) begin
              state_q   <= StIdle;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q    <= StData;
              count_q    <= in_data;
              word_idx_q <= '0;
              byte_idx_q <= '0;
              csum_q     <= '0;
            end
          end
        end
        StData: begin
          if (accept) begin
            csum_q     <= csum_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_q[7:0]   <= in_data;
              2'd1: word_buf_q[15:8]  <= in_data;
              2'd2: word_buf_q[23:16] <= in_data;
              default: begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= ADDR_WIDTH'(word_idx_q);
                mem_wdata_q <= {in_data, word_buf_q};
                word_idx_q  <= word_idx_q + 8'd1;
                if (word_idx_q == count_q - 8'd1) begin
                  state_q <= StCheck;
                end
              end
            endcase
          end
        end
        StCheck: begin
          if (accept) begin
            if (in_data != csum_q) begin
              err_q <= 1'b1;
            end
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          cpu_rst_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_prog_loader.sv
// Self-checking bench for sm_prog_loader: two instances (default and 2-bit address) share
// one byte stream; expected writes are derived per frame from the frame contents.
module tb_sm_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready, mem_we, cpu_rst, done, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic        in_ready2, mem_we2, cpu_rst2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  sm_prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  sm_prog_loader #(.ADDR_WIDTH(2)) dut_w2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready2),
    .mem_we    (mem_we2),
    .mem_addr  (mem_addr2),
    .mem_wdata (mem_wdata2),
    .cpu_rst   (cpu_rst2),
    .done      (done2),
    .err       (err2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ready_viol = 0;
  int obs_a[$];
  int obs_a2[$];
  logic [31:0] obs_d[$];
  logic [31:0] obs_d2[$];
  logic [31:0] fr_words[$];

  // Observer: collects writes and done pulses, flags in_ready outside of the done cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_a.push_back(int'(mem_addr));
      obs_d.push_back(mem_wdata);
    end
    if (mem_we2 === 1'b1) begin
      obs_a2.push_back(int'(mem_addr2));
      obs_d2.push_back(mem_wdata2);
    end
    if (done === 1'b1) done_cnt++;
    if (!rst && ((in_ready !== ~done) || (in_ready2 !== in_ready) || (done2 !== done)
        || (cpu_rst2 !== cpu_rst) || (err2 !== err))) ready_viol++;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_obs();
    obs_a.delete();
    obs_a2.delete();
    obs_d.delete();
    obs_d2.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: byte %02h never accepted, in_ready=%b want 1", b, in_ready);
    end
  endtask

  // Sends one frame built from fr_words and checks writes, done, err and cpu_rst against
  // what the frame contents dictate.
  task automatic run_frame(input int n, input logic [7:0] csum_flip, input int max_gap,
                           input string name);
    logic [7:0] x;
    logic [7:0] csum;
    logic       exp_err;
    int         d0;
    int         v0;
    clear_obs();
    d0 = done_cnt;
    v0 = ready_viol;
    exp_err = (csum_flip != 8'd0);
    send_byte(8'hA5, max_gap);
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++; $display("FAIL %s sync_cpu_rst: got %b want 1", name, cpu_rst);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL %s sync_err_clear: got %b want 0", name, err);
    end
    send_byte(8'(n), max_gap);
    csum = 8'd0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        x = fr_words[i][8*k +: 8];
        csum ^= x;
        send_byte(x, max_gap);
      end
      checks++;
      if (cpu_rst !== 1'b1) begin
        errors++; $display("FAIL %s word%0d_cpu_rst: got %b want 1", name, i, cpu_rst);
      end
    end
    send_byte(csum ^ csum_flip, max_gap);
    checks++;
    if ({done, in_ready, cpu_rst, err} !== {1'b1, 1'b0, 1'b1, exp_err}) begin
      errors++;
      $display("FAIL %s done_cycle: got done/rdy/cpu_rst/err=%b%b%b%b want 101%b",
               name, done, in_ready, cpu_rst, err, exp_err);
    end
    tick();
    checks++;
    if ({done, in_ready, cpu_rst, err} !== {1'b0, 1'b1, 1'b0, exp_err}) begin
      errors++;
      $display("FAIL %s after_done: got done/rdy/cpu_rst/err=%b%b%b%b want 010%b",
               name, done, in_ready, cpu_rst, err, exp_err);
    end
    checks++;
    if (obs_a.size() != n || obs_a2.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d/%0d want %0d", name, obs_a.size(), obs_a2.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_a[i] != i % 64 || obs_d[i] !== fr_words[i]) begin
          errors++;
          $display("FAIL %s write%0d: got addr %0d data %08h want addr %0d data %08h",
                   name, i, obs_a[i], obs_d[i], i % 64, fr_words[i]);
        end
        checks++;
        if (obs_a2[i] != i % 4 || obs_d2[i] !== fr_words[i]) begin
          errors++;
          $display("FAIL %s write%0d_aw2: got addr %0d data %08h want addr %0d data %08h",
                   name, i, obs_a2[i], obs_d2[i], i % 4, fr_words[i]);
        end
      end
    end
    checks++;
    if (int'(mem_addr) != (n - 1) % 64 || mem_wdata !== fr_words[n-1] ||
        int'(mem_addr2) != (n - 1) % 4) begin
      errors++;
      $display("FAIL %s hold_last: got addr %0d/%0d data %08h want addr %0d/%0d data %08h",
               name, mem_addr, mem_addr2, mem_wdata, (n - 1) % 64, (n - 1) % 4, fr_words[n-1]);
    end
    checks++;
    if (done_cnt - d0 != 1 || ready_viol != v0) begin
      errors++;
      $display("FAIL %s pulses: got done=%0d ready_viol=%0d want done=1 ready_viol=0",
               name, done_cnt - d0, ready_viol - v0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    tick();
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !== {1'b1, 1'b0, 6'd0,
        32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b we=%b addr=%0d wdata=%08h cpu_rst=%b done=%b err=%b want 1 0 0 0 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++; $display("FAIL reset_priority: cpu_rst got %b want 0", cpu_rst);
    end
    done_cnt = 0;
    ready_viol = 0;
  endtask

  task automatic test_basic();
    fr_words = '{32'h00100513};
    run_frame(1, 8'h00, 0, "basic");
  endtask

  task automatic test_bad_csum();
    fr_words = '{32'h00100513};
    run_frame(1, 8'h01, 0, "bad_csum");
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky_idle: got %b want 1", err);
    end
    send_byte(8'h00, 0);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky_junk: got %b want 1", err);
    end
    send_byte(8'hA5, 0);
    checks++;
    if (err !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++; $display("FAIL err_clear_on_sync: got err=%b cpu_rst=%b want 0 1", err, cpu_rst);
    end
    send_byte(8'h00, 0);
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++; $display("FAIL zero_count_release: cpu_rst got %b want 0", cpu_rst);
    end
  endtask

  task automatic test_junk();
    int d0;
    clear_obs();
    d0 = done_cnt;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++; $display("FAIL junk_dropped: cpu_rst got %b want 0", cpu_rst);
    end
    send_byte(8'hA5, 0);
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++; $display("FAIL junk_sync: cpu_rst got %b want 1", cpu_rst);
    end
    send_byte(8'h00, 0);
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++; $display("FAIL junk_n0_release: cpu_rst got %b want 0", cpu_rst);
    end
    tick();
    checks++;
    if (obs_a.size() != 0 || done_cnt != d0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL junk_no_effect: got writes=%0d done=%0d cpu_rst=%b want 0 0 0",
               obs_a.size(), done_cnt - d0, cpu_rst);
    end
  endtask

  task automatic test_wrap();
    fr_words.delete();
    for (int i = 0; i < 5; i++) fr_words.push_back(32'h11111111 * (i + 1));
    run_frame(5, 8'h00, 0, "wrap");
    checks++;
    if (mem_addr2 !== 2'd0 || mem_wdata2 !== 32'h55555555) begin
      errors++;
      $display("FAIL wrap_final: got addr %0d data %08h want addr 0 data 55555555",
               mem_addr2, mem_wdata2);
    end
  endtask

  task automatic test_gaps();
    int          n;
    logic [7:0]  flip;
    for (int f = 0; f < 5; f++) begin
      n = (f == 0) ? 3 : int'($urandom_range(7, 1));
      fr_words.delete();
      for (int i = 0; i < n; i++) fr_words.push_back($urandom);
      fr_words[0][15:8] = 8'hA5;
      flip = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      run_frame(n, flip, 3, "gaps");
    end
  endtask

  task automatic test_abort();
    logic [31:0] w0;
    w0 = 32'hDEADBEEF;
    clear_obs();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h56;
    tick();
    checks++;
    if ({cpu_rst, mem_we, done, err, in_ready} !== 5'b00001 || mem_addr !== 6'd0) begin
      errors++;
      $display("FAIL abort_state: got cpu_rst/we/done/err/rdy=%b%b%b%b%b addr=%0d want 00001 addr 0",
               cpu_rst, mem_we, done, err, in_ready, mem_addr);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_a.size() != 1 || obs_d.size() != 1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL abort_writes: got writes=%0d cpu_rst=%b want 1 0", obs_a.size(), cpu_rst);
    end else begin
      checks++;
      if (obs_d[0] !== w0 || obs_a[0] != 0) begin
        errors++;
        $display("FAIL abort_word0: got addr %0d data %08h want addr 0 data %08h",
                 obs_a[0], obs_d[0], w0);
      end
    end
    fr_words = '{$urandom, $urandom};
    run_frame(2, 8'h00, 0, "after_abort");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_junk();
    test_wrap();
    test_gaps();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
